// File: rtl/scalar_issue_ctrl.sv
// Issue/sequencer for the CGRA scalar PE: instruction buffer, register file,
// two-stage FD/EX pipeline with EX->FD forwarding, bne redirect and halt detection.
`timescale 1ns/100ps
module scalar_issue_ctrl #(
  parameter int dwidth_int  = 32,
  parameter int dwidth_inst = 32,
  parameter int NINSTR      = 16,
  parameter int NREG        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      prog_we,
  input  logic [$clog2(NINSTR)-1:0] prog_addr,
  input  logic [dwidth_inst-1:0]    prog_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               retired,
  input  logic [$clog2(NREG)-1:0]   dbg_raddr,
  output logic [dwidth_int-1:0]     dbg_rdata,
  output logic [dwidth_int-1:0]     inp1,
  output logic [dwidth_int-1:0]     inp2,
  output logic [dwidth_int-1:0]     R_immediate,
  output logic [2:0]                op_scalar,
  input  logic [dwidth_int-1:0]     out1,
  input  logic                      flag_neq
);
  localparam int PW = $clog2(NINSTR);
  localparam int RW = $clog2(NREG);

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_BUB  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  function automatic logic signed [dwidth_int-1:0] sext_i(input logic signed [11:0] v);
    return dwidth_int'(v);
  endfunction

  function automatic logic signed [dwidth_int-1:0] sext_b(input logic signed [12:0] v);
    return dwidth_int'(v);
  endfunction

  function automatic logic signed [dwidth_int-1:0] sext_u(input logic signed [31:0] v);
    return dwidth_int'(v);
  endfunction

  logic [dwidth_inst-1:0] imem [NINSTR];
  logic [dwidth_int-1:0]  rf   [NREG];

  // FD stage (p0): fetch, decode, register read with forwarding
  logic [PW-1:0]                pc_p0, pc_nx;
  logic [dwidth_inst-1:0]       inst_p0;
  logic [2:0]                   op_p0;
  logic                         halt_p0, wen_p0;
  logic [RW-1:0]                rd_p0, rs1_p0, rs2_p0;
  logic signed [dwidth_int-1:0] imm_p0;
  logic [dwidth_int-1:0]        rs1_val_p0, rs2_val_p0;

  // EX stage (p1): drives the PE, writes back, resolves branch/halt
  logic                         vld_p1, halt_p1, wen_p1;
  logic [2:0]                   op_p1;
  logic [RW-1:0]                rd_p1;
  logic [PW-1:0]                pc_p1;
  logic [dwidth_int-1:0]        inp1_p1, inp2_p1;
  logic signed [dwidth_int-1:0] imm_p1;

  logic                         vld_nx, halt_nx, wen_nx;
  logic [2:0]                   op_nx;
  logic [RW-1:0]                rd_nx;
  logic [dwidth_int-1:0]        inp1_nx, inp2_nx;
  logic signed [dwidth_int-1:0] imm_nx;

  logic                  clr, issue, halt_ex, taken_p1, wb_en, ret_inc;
  logic [dwidth_int-1:0] wb_data;
  logic [PW-1:0]         target_p1;

  assign inst_p0 = imem[pc_p0];
  assign rd_p0   = inst_p0[7 +: RW];
  assign rs1_p0  = inst_p0[15 +: RW];
  assign rs2_p0  = inst_p0[20 +: RW];

  always_comb begin
    op_p0   = OP_BUB;
    halt_p0 = 1'b1;
    imm_p0  = '0;
    if (inst_p0[6:0] == 7'b0110111) begin
      op_p0   = OP_LUI;
      halt_p0 = 1'b0;
      imm_p0  = sext_u({inst_p0[31:12], 12'b0});
    end else if (inst_p0[6:0] == 7'b0010011 && inst_p0[14:12] == 3'b000) begin
      op_p0   = OP_ADDI;
      halt_p0 = 1'b0;
      imm_p0  = sext_i(inst_p0[31:20]);
    end else if (inst_p0[6:0] == 7'b0110011 && inst_p0[14:12] == 3'b000 &&
                 inst_p0[31:25] == 7'b0) begin
      op_p0   = OP_ADD;
      halt_p0 = 1'b0;
    end else if (inst_p0[6:0] == 7'b1100011 && inst_p0[14:12] == 3'b001) begin
      op_p0   = OP_BNE;
      halt_p0 = 1'b0;
      imm_p0  = sext_b({inst_p0[31], inst_p0[7], inst_p0[30:25], inst_p0[11:8], 1'b0});
    end
  end

  assign wen_p0 = (op_p0 == OP_LUI || op_p0 == OP_ADDI || op_p0 == OP_ADD) && (rd_p0 != '0);

  // The PE returns 0 for lui, so the upper immediate is written back from here.
  assign wb_data   = (op_p1 == OP_LUI) ? imm_p1 : out1;
  assign wb_en     = (state == S_RUN) && vld_p1 && wen_p1;
  assign halt_ex   = (state == S_RUN) && vld_p1 && halt_p1;
  assign taken_p1  = (state == S_RUN) && vld_p1 && (op_p1 == OP_BNE) && flag_neq;
  assign target_p1 = pc_p1 + imm_p1[PW+1:2];
  assign ret_inc   = (state == S_RUN) && vld_p1 && !halt_p1;

  assign rs1_val_p0 = (wb_en && rd_p1 == rs1_p0) ? wb_data : rf[rs1_p0];
  assign rs2_val_p0 = (wb_en && rd_p1 == rs2_p0) ? wb_data : rf[rs2_p0];

  always_comb begin
    state_nx = state;
    busy     = (state == S_RUN);
    done     = 1'b0;
    clr      = 1'b0;
    issue    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_RUN;
          clr      = 1'b1;
        end
      end
      S_RUN: begin
        if (halt_ex) begin
          state_nx = S_DONE;
          done     = 1'b1;
        end else begin
          issue = !taken_p1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    vld_nx  = 1'b0;
    halt_nx = 1'b0;
    wen_nx  = 1'b0;
    op_nx   = OP_BUB;
    rd_nx   = '0;
    inp1_nx = '0;
    inp2_nx = '0;
    imm_nx  = '0;
    pc_nx   = pc_p0;
    if (clr) begin
      pc_nx = '0;
    end else if (taken_p1) begin
      pc_nx = target_p1;
    end else if (issue) begin
      pc_nx   = pc_p0 + PW'(1);
      vld_nx  = 1'b1;
      halt_nx = halt_p0;
      wen_nx  = wen_p0;
      op_nx   = op_p0;
      rd_nx   = rd_p0;
      inp1_nx = rs1_val_p0;
      inp2_nx = rs2_val_p0;
      imm_nx  = imm_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc_p0   <= '0;
      vld_p1  <= 1'b0;
      halt_p1 <= 1'b0;
      wen_p1  <= 1'b0;
      op_p1   <= OP_BUB;
      rd_p1   <= '0;
      pc_p1   <= '0;
      inp1_p1 <= '0;
      inp2_p1 <= '0;
      imm_p1  <= '0;
      retired <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      state   <= state_nx;
      pc_p0   <= pc_nx;
      vld_p1  <= vld_nx;
      halt_p1 <= halt_nx;
      wen_p1  <= wen_nx;
      op_p1   <= op_nx;
      rd_p1   <= rd_nx;
      pc_p1   <= pc_p0;
      inp1_p1 <= inp1_nx;
      inp2_p1 <= inp2_nx;
      imm_p1  <= imm_nx;
      if (clr) begin
        retired <= '0;
        for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
        if (ret_inc) retired <= retired + 16'd1;
        if (wb_en) rf[rd_p1] <= wb_data;
      end
    end
  end

  // Program memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (prog_we && state != S_RUN) imem[prog_addr] <= prog_data;
  end

  assign dbg_rdata   = (dbg_raddr == '0) ? '0 : rf[dbg_raddr];
  assign inp1        = inp1_p1;
  assign inp2        = inp2_p1;
  assign R_immediate = imm_p1;
  assign op_scalar   = op_p1;

endmodule

// File: tb/tb_scalar_issue_ctrl.sv
// Scoreboard bench for scalar_issue_ctrl with a behavioural scalar PE;
// run expectations are queued at start and checked when done pulses.
`timescale 1ns/100ps
module tb_scalar_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        start = 1'b0;
  logic        busy, done;
  logic [15:0] retired;
  logic [2:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata, inp1, inp2, R_immediate, out1;
  logic [2:0]  op_scalar;
  logic        flag_neq;

  scalar_issue_ctrl #(.dwidth_int(32), .dwidth_inst(32), .NINSTR(16), .NREG(8)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy), .done(done), .retired(retired),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .inp1(inp1), .inp2(inp2), .R_immediate(R_immediate), .op_scalar(op_scalar),
    .out1(out1), .flag_neq(flag_neq)
  );

  always #5 clk = ~clk;

  // Scalar PE model
  always_comb begin
    out1     = '0;
    flag_neq = 1'b0;
    case (op_scalar)
      3'b001:  out1 = inp1 + R_immediate;
      3'b011:  out1 = inp1 + inp2;
      3'b010:  flag_neq = (inp1 != inp2);
      default: out1 = '0;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]      lat;
    logic [15:0]      ret;
    logic [31:0]      bub;
    logic [7:0][31:0] regs;
  } exp_t;

  exp_t runq[$];
  int n_chk = 0, n_fail = 0, start_cyc = 0, bub = 0, done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic sweep_regs(input string tag, input logic [7:0][31:0] r);
    for (int i = 0; i < 8; i++) begin
      dbg_raddr = 3'(i);
      #0.2;
      check($sformatf("%s_x%0d", tag, i), dbg_rdata, r[i]);
    end
  endtask

  task automatic load(input int addr, input logic [31:0] w);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'(addr);
    prog_data = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic go(input exp_t e, input bit expect_done);
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    bub       = 0;
    if (expect_done) runq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 400; k++) begin
      if (runq.size() == 0) break;
      @(negedge clk);
    end
    if (runq.size() != 0) begin
      check({tag, "_timeout"}, 32'(runq.size()), 32'd0);
      runq.delete();
    end
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && done !== 1'b1 && op_scalar == 3'b111 && cyc - start_cyc > 1) bub++;
      if (done === 1'b1) begin
        done_cnt++;
        if (runq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = runq.pop_front();
          check("done_latency", 32'(cyc - start_cyc), e.lat);
          check("retired", {16'd0, retired}, {16'd0, e.ret});
          check("squash_bubbles", 32'(bub), e.bub);
          sweep_regs("reg", e.regs);
        end
      end
    end
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_op"}, {29'd0, op_scalar}, 32'd7);
    check({tag, "_inp1"}, inp1, 32'd0);
    check({tag, "_inp2"}, inp2, 32'd0);
    check({tag, "_imm"}, R_immediate, 32'd0);
    check({tag, "_retired"}, {16'd0, retired}, 32'd0);
    sweep_regs({tag, "_reg"}, '0);
  endtask

  initial begin
    fork
      monitor();
      begin
        exp_t e1, e_lui, e_loop;
        int dc;
        e1 = '0;     e1.lat = 5;      e1.ret = 3;     e1.bub = 0;
        e1.regs[1] = 32'd5; e1.regs[2] = 32'd8; e1.regs[3] = 32'd13;
        e_lui = '0;  e_lui.lat = 5;   e_lui.ret = 3;  e_lui.bub = 0;
        e_lui.regs[5] = 32'h1234_5000; e_lui.regs[6] = 32'h1234_5000;
        e_loop = '0; e_loop.lat = 15; e_loop.ret = 10; e_loop.bub = 3;
        e_loop.regs[1] = 32'd4; e_loop.regs[2] = 32'd4;

        repeat (2) @(negedge clk);
        check_idle_state("reset");
        rst = 1'b1;

        // addi x1,x0,5; addi x2,x1,3; add x3,x1,x2; halt
        load(0, 32'h0050_0093); load(1, 32'h0030_8113);
        load(2, 32'h0020_81B3); load(3, 32'h0000_0000);
        go(e1, 1'b1); drain("fwd");

        // lui x5,0x12345; addi x0,x0,7; add x6,x5,x0; halt (loaded while DONE)
        load(0, 32'h1234_52B7); load(1, 32'h0070_0013);
        load(2, 32'h0002_8333); load(3, 32'h0000_0000);
        go(e_lui, 1'b1); drain("lui");

        // addi x1,x0,0; addi x2,x0,4; L: addi x1,x1,1; bne x1,x2,L; halt
        load(0, 32'h0000_0093); load(1, 32'h0040_0113); load(2, 32'h0010_8093);
        load(3, 32'hFE20_9EE3); load(4, 32'h0000_0000);
        go(e_loop, 1'b1); drain("loop");

        // prog_we and start pulsed mid-run must both be ignored
        go(e_loop, 1'b1);
        repeat (2) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 32'h0090_0093; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        drain("busy_ignore");
        go(e_loop, 1'b1); drain("rerun");

        // reset in the middle of the loop
        go(e_loop, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_state("midreset");
        rst = 1'b1;
        dc = done_cnt;
        repeat (25) @(negedge clk);
        check("midreset_no_done", 32'(done_cnt), 32'(dc));
        check("midreset_still_idle", {31'd0, busy}, 32'd0);
        go(e_loop, 1'b1); drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    join_any
  end
endmodule
